// File: rtl/matvec_pkg.sv
// -----------------------------------------------------------------------------
// matvec_pkg
// Shared definitions for the matrix-vector multiplier front end: the operand
// loader state encoding and the operand-FIFO geometry.
// -----------------------------------------------------------------------------
package matvec_pkg;

    localparam int NUM_FIFOS      = 9;  // A0..A7 rows plus vector B
    localparam int BYTES_PER_WORD = 8;  // one 64-bit memory word per FIFO
    localparam int VEC_FIFO_IDX   = 8;  // FIFO that receives vector B

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        UNPACK = 3'd3,
        DONE   = 3'd4
    } loader_state_e;

endpackage : matvec_pkg

// File: rtl/byte_unpacker.sv
// -----------------------------------------------------------------------------
// byte_unpacker
// Holds one memory word and hands it out one byte per accepted write, most
// significant byte first.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture load_data and restart at byte 0
//   load_data   word to unpack
//   advance     a byte slot is being offered this cycle
//   stall       the destination cannot take the byte; the counter holds
//   last        current byte is the final byte of the word
//   byte_out    current byte
// -----------------------------------------------------------------------------
module byte_unpacker #(
    parameter int BYTES_PER_WORD = matvec_pkg::BYTES_PER_WORD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [8*BYTES_PER_WORD-1:0]   load_data,
    input  logic                          advance,
    input  logic                          stall,
    output logic                          last,
    output logic [7:0]                    byte_out
);

    localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

    // Byte lane i of word_q is bits [8i+7:8i], so lane LAST_IDX is the MSB byte.
    logic [BYTES_PER_WORD-1:0][7:0] word_q, word_d;
    logic [CNT_W-1:0]               byte_cnt_q, byte_cnt_d;

    assign last     = (byte_cnt_q == LAST_IDX);
    assign byte_out = word_q[LAST_IDX - byte_cnt_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        if (load) begin
            word_d     = load_data;
            byte_cnt_d = '0;
        end else if (advance && !stall) begin
            byte_cnt_d = last ? '0 : byte_cnt_q + 1'b1;
        end
    end

    // NOTE: the word register is a plain 64-bit flop, not a RAM, so resetting it is cheap and gives a defined value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule : byte_unpacker

// File: rtl/mem_fifo_loader.sv
// -----------------------------------------------------------------------------
// mem_fifo_loader
// On fill, reads NUM_FIFOS consecutive words from memory (Avalon-MM style read)
// and writes each word, byte by byte MSB first, into its own operand FIFO.
// Words 0..7 are matrix rows A0..A7, the last word is vector B.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fill                start a load sequence (sampled only in IDLE)
//   mem_address         word address of the current read
//   mem_read            read request, held until accepted
//   mem_waitrequest     memory not ready
//   mem_readdata        returned word
//   mem_readdatavalid   mem_readdata valid this cycle
//   fifo_full           per-FIFO full flags
//   fifo_addr           one-hot FIFO select, zero when not writing
//   fifo_din            byte to write
//   en_fifo_write       write strobe
//   busy                sequence in progress
//   done                one-cycle pulse after the final byte
// -----------------------------------------------------------------------------
module mem_fifo_loader #(
    parameter int                NUM_FIFOS      = matvec_pkg::NUM_FIFOS,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                BYTES_PER_WORD = matvec_pkg::BYTES_PER_WORD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fill,
    output logic [ADDR_W-1:0]             mem_address,
    output logic                          mem_read,
    input  logic                          mem_waitrequest,
    input  logic [8*BYTES_PER_WORD-1:0]   mem_readdata,
    input  logic                          mem_readdatavalid,
    input  logic [NUM_FIFOS-1:0]          fifo_full,
    output logic [NUM_FIFOS-1:0]          fifo_addr,
    output logic [7:0]                    fifo_din,
    output logic                          en_fifo_write,
    output logic                          busy,
    output logic                          done
);

    import matvec_pkg::*;

    localparam int IDX_W = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_FIFOS - 1);

    loader_state_e    state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;

    logic       in_unpack;
    logic       sel_full;
    logic       wr_fire;
    logic       load_word;
    logic       unpack_last;
    logic [7:0] unpack_byte;

    assign in_unpack = (state_q == UNPACK);
    assign sel_full  = fifo_full[word_idx_q];
    assign wr_fire   = in_unpack && !sel_full;
    // Read data is only meaningful while a read is outstanding.
    assign load_word = (state_q == WAIT) && mem_readdatavalid;

    byte_unpacker #(
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_word),
        .load_data (mem_readdata),
        .advance   (in_unpack),
        .stall     (sel_full),
        .last      (unpack_last),
        .byte_out  (unpack_byte)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        case (state_q)
            IDLE: begin
                if (fill) begin
                    state_d    = REQ;
                    word_idx_d = '0;
                end
            end
            REQ: begin
                if (!mem_waitrequest) state_d = WAIT;
            end
            WAIT: begin
                if (mem_readdatavalid) state_d = UNPACK;
            end
            UNPACK: begin
                if (wr_fire && unpack_last) begin
                    if (word_idx_q == LAST_WORD) begin
                        state_d = DONE;
                    end else begin
                        state_d    = REQ;
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;  // fill is deliberately not sampled here
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
        end
    end

    // Outputs decode the registered state; only the write strobe also
    // follows the live full flag so a full FIFO never sees a write.
    assign mem_read      = (state_q == REQ);
    assign mem_address   = mem_read ? (BASE_ADDR + ADDR_W'(word_idx_q)) : '0;
    assign en_fifo_write = wr_fire;
    assign fifo_addr     = wr_fire ? (NUM_FIFOS'(1) << word_idx_q) : '0;
    assign fifo_din      = in_unpack ? unpack_byte : '0;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule : mem_fifo_loader

// File: doc/mem_fifo_loader.md
Name: mem_fifo_loader

Overview:
Upstream stage of the matrix-vector multiplier. On a fill request it reads nine 64-bit words from the memory wrapper over an Avalon-MM-style read interface. Each word is unpacked into eight bytes, which are written into one of the nine operand FIFOs. Words 0-7 are matrix rows A0-A7 and go to FIFOs 0-7; word 8 is vector B and goes to FIFO 8.

Parameters:
NUM_FIFOS, 9, number of destination FIFOs and memory words read per fill
ADDR_W, 32, memory word-address width
BASE_ADDR, 0, word address of row 0; word k is read from BASE_ADDR+k
BYTES_PER_WORD, 8, bytes unpacked per 64-bit word

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
fill  input  1  start a load sequence; sampled only in IDLE
mem_address  output  ADDR_W  word address of the current read
mem_read  output  1  read request, held until accepted
mem_waitrequest  input  1  memory not ready; request is accepted on a cycle with mem_read=1 and mem_waitrequest=0
mem_readdata  input  64  returned word
mem_readdatavalid  input  1  mem_readdata valid this cycle
fifo_full  input  NUM_FIFOS  full flag per FIFO
fifo_addr  output  NUM_FIFOS  one-hot FIFO select; all zero when not writing
fifo_din  output  8  byte to write
en_fifo_write  output  1  write strobe to the FIFO selected by fifo_addr
busy  output  1  high from the cycle after fill is accepted until the return to IDLE
done  output  1  single-cycle pulse when the last byte of word 8 has been written

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous active-low, rst_n. Reset is asynchronous and active-low on rst_n; all state registers are cleared on the negedge of rst_n.
- Reset values: state=IDLE, word index=0, byte index=0, word register=0. All outputs are 0.
- IDLE: when fill=1, go to REQ and set the word index to 0. fill=0 keeps the block in IDLE.
- REQ:
  - mem_read=1, mem_address=BASE_ADDR+word index.
  - mem_read and mem_address stay stable while mem_waitrequest=1.
  - When mem_waitrequest=0, the request is accepted; go to WAIT.
- WAIT:
  - mem_read=0.
  - When mem_readdatavalid=1, latch mem_readdata into the word register, set the byte index to 0, go to UNPACK.
  - There is no timeout; the block waits indefinitely.
- UNPACK, write rule:
  - Each cycle, present byte b = word[63-8b -: 8] (MSB first) on fifo_din.
  - fifo_addr is the one-hot code for the word index.
  - en_fifo_write = ~fifo_full[word index].
- UNPACK, full stall: while the selected FIFO is full, en_fifo_write=0, fifo_addr=0, and the byte index holds. Resume when full deasserts.
- UNPACK, advance: the byte index advances only on a cycle where a write occurs. After byte 7 is written:
  - word index < NUM_FIFOS-1: increment the word index and go to REQ.
  - otherwise: go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- busy: high in REQ, WAIT, UNPACK and DONE.
- Ignored inputs:
  - fill outside IDLE is ignored; there is no queuing.
  - mem_readdatavalid outside WAIT is ignored and does not alter the word register.
- Latency:
  - fill to first mem_read: 1 cycle.
  - readdatavalid to first en_fifo_write: 1 cycle.
  - Minimum total sequence, with zero waitrequest, 1-cycle read latency and no full stalls: 9 x (1 REQ + 1 WAIT + 8 UNPACK) + 1 DONE = 91 cycles after fill.
- Write ordering: exactly 8 writes per FIFO per sequence; exactly 72 writes in total. FIFO k is written only while the word index is k.
- Reset mid-operation: return immediately to IDLE with all outputs 0. A partially filled FIFO is not cleared; the FIFOs are cleared by their own reset or Clr.
- Simultaneous events:
  - In the DONE cycle, fill=1 is ignored.
  - In IDLE, fill=1 on the first cycle after reset release is accepted.

Decomposition:
- Shared package matvec_pkg holds:
  - the loader state enum (IDLE, REQ, WAIT, UNPACK, DONE), 3 bits;
  - the constants NUM_FIFOS=9, BYTES_PER_WORD=8 and VEC_FIFO_IDX=8.
- One sub-module is natural: byte_unpacker. It holds the 64-bit load register and the 3-bit byte counter, with load, advance and stall inputs, and last and byte_out outputs.
- The FSM and the memory handshake stay in the top module.

Test Plan:
1. Ideal memory: waitrequest=0, 1-cycle readdatavalid, word k = {8{k+1}} bytes.
   -> 72 writes; FIFO k receives eight 8'h(k+1); done pulses at cycle 91 after fill; busy is 0 after that.
2. Byte order: word 0 = 64'h0102030405060708.
   -> FIFO 0 receives 01,02,...,08 in order with fifo_addr=9'b000000001.
3. Backpressure: mem_waitrequest=1 for 5 cycles on word 3.
   -> mem_read=1 and mem_address=BASE_ADDR+3 are stable throughout; no FIFO write occurs during the stall.
4. FIFO full: fifo_full[8]=1 for 10 cycles after the second vector byte.
   -> en_fifo_write=0 for those cycles; byte 3 is written on the first cycle after full clears; done is delayed by exactly 10 cycles.
5. Spurious inputs: pulse fill while in UNPACK; assert readdatavalid with data FF..FF while in REQ.
   -> no restart; the word register is unchanged; the written data matches the expected words.
6. Reset mid-sequence: assert rst_n=0 during word 5 UNPACK.
   -> all outputs are 0 immediately; after release and a new fill, the sequence restarts at address BASE_ADDR+0.
